// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage: decodes the immediate at capture and
// holds it in a main output register backed by one skid register.
module imm_gen_stage #(
  parameter int INST_WIDTH    = 32,
  parameter int IMM_SEL_WIDTH = 3,
  parameter int REG_WIDTH     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INST_WIDTH-1:0]    inst,
  input  logic [IMM_SEL_WIDTH-1:0] imm_sel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [REG_WIDTH-1:0]     imm_out,
  output logic [INST_WIDTH-1:0]    inst_out,
  output logic                     sel_err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic SH_MSB_EN = (REG_WIDTH == 64);

  state_t                 state, state_next;
  logic                   accept, drain;
  logic                   load_main, load_skid, move_skid;
  logic [31:0]            raw;
  logic                   err_calc;
  logic [REG_WIDTH-1:0]   imm_calc;
  logic [REG_WIDTH-1:0]   skid_imm;
  logic [INST_WIDTH-1:0]  skid_inst;
  logic                   skid_err;

  // Every format is first formed as a sign-correct 32-bit value; widening
  // to REG_WIDTH then only needs bit 31 replicated.
  always_comb begin
    raw      = '0;
    err_calc = 1'b0;
    case (imm_sel)
      3'd0: raw = {{20{inst[31]}}, inst[31:20]};
      3'd1: raw = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      3'd2: raw = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      3'd3: raw = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      3'd4: raw = {inst[31:12], 12'b0};
      3'd5: raw = {27'b0, inst[19:15]};
      3'd6: raw = {26'b0, SH_MSB_EN & inst[25], inst[24:20]};
      default: err_calc = 1'b1;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < REG_WIDTH; gi++) begin : g_ext
      if (gi < 32) begin : g_low
        assign imm_calc[gi] = raw[gi];
      end else begin : g_high
        assign imm_calc[gi] = raw[31];
      end
    end
  endgenerate

  // in_ready depends only on the state register, never on out_ready.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_main  = 1'b0;
    load_skid  = 1'b0;
    move_skid  = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            load_main  = 1'b1;
            state_next = HALF;
          end
        end
        HALF: begin
          if (accept && drain) begin
            load_main = 1'b1;
          end else if (accept) begin
            load_skid  = 1'b1;
            state_next = FULL;
          end else if (drain) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            move_skid  = 1'b1;
            state_next = HALF;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imm_out   <= '0;
      inst_out  <= '0;
      sel_err   <= 1'b0;
      skid_imm  <= '0;
      skid_inst <= '0;
      skid_err  <= 1'b0;
    end else begin
      if (load_main) begin
        imm_out  <= imm_calc;
        inst_out <= inst;
        sel_err  <= err_calc;
      end else if (move_skid) begin
        imm_out  <= skid_imm;
        inst_out <= skid_inst;
        sel_err  <= skid_err;
      end
      if (load_skid) begin
        skid_imm  <= imm_calc;
        skid_inst <= inst;
        skid_err  <= err_calc;
      end
    end
  end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Scoreboard bench: two instances (32- and 64-bit) share stimulus; a monitor
// checks every output transfer against a signed-arithmetic reference model.
module tb_imm_gen_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] inst;
  logic [2:0]  imm_sel;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, err_a;
  logic [31:0] imm_a, inst_a;
  logic        in_ready_b, out_valid_b, err_b;
  logic [63:0] imm_b;
  logic [31:0] inst_b;

  typedef struct {
    logic [31:0] i;
    logic [2:0]  s;
  } entry_t;

  entry_t q[$];
  int total = 0;
  int bad   = 0;
  int outs  = 0;

  imm_gen_stage #(.INST_WIDTH(32), .IMM_SEL_WIDTH(3), .REG_WIDTH(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .inst(inst), .imm_sel(imm_sel), .out_valid(out_valid_a), .out_ready(out_ready),
    .imm_out(imm_a), .inst_out(inst_a), .sel_err(err_a)
  );

  imm_gen_stage #(.INST_WIDTH(32), .IMM_SEL_WIDTH(3), .REG_WIDTH(64)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .inst(inst), .imm_sel(imm_sel), .out_valid(out_valid_b), .out_ready(out_ready),
    .imm_out(imm_b), .inst_out(inst_b), .sel_err(err_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] model(input logic [31:0] i, input logic [2:0] s, input int w);
    longint v;
    logic [63:0] r;
    case (s)
      3'd0: v = $signed(i[31:20]);
      3'd1: v = $signed({i[31:25], i[11:7]});
      3'd2: v = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
      3'd3: v = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
      3'd4: v = longint'($signed(i[31:12])) * 4096;
      3'd5: v = longint'(i[19:15]);
      3'd6: v = longint'(i[25:20]) % ((w == 64) ? 64 : 32);
      default: v = 0;
    endcase
    r = v;
    if (w == 32) r = {32'h0, r[31:0]};
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one entry and hold it until the 32-bit instance accepts it.
  task automatic send(input logic [31:0] i, input logic [2:0] s);
    bit acc;
    int n;
    n = 0;
    in_valid = 1'b1;
    inst     = i;
    imm_sel  = s;
    do begin
      acc = in_ready_a;
      tick();
      n++;
    end while (!acc && n < 50);
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 expected accept within 50 cycles");
    end
    in_valid = 1'b0;
    inst     = $urandom;
    imm_sel  = 3'($urandom_range(7));
  endtask

  task automatic sweep(input logic [31:0] i, input logic [2:0] s,
                       input logic [31:0] ea, input logic [63:0] eb, input logic ee);
    out_ready = 1'b1;
    send(i, s);
    chk($sformatf("lat_valid_sel%0d", s), 64'(out_valid_a), 64'd1);
    chk($sformatf("imm32_sel%0d", s), 64'(imm_a), 64'(ea));
    chk($sformatf("imm64_sel%0d", s), imm_b, eb);
    chk($sformatf("err_sel%0d", s), 64'(err_a), 64'(ee));
  endtask

  // Monitor: samples at the falling edge what the next rising edge transfers.
  initial begin
    entry_t e;
    logic [63:0] e32, e64;
    logic hold;
    logic [31:0] h_imm_a, h_inst;
    logic [63:0] h_imm_b;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n || flush) begin
        q.delete();
        hold = 1'b0;
        continue;
      end
      if (hold) begin
        chk("hold_imm32", 64'(imm_a), 64'(h_imm_a));
        chk("hold_imm64", imm_b, h_imm_b);
        chk("hold_inst", 64'(inst_a), 64'(h_inst));
      end
      if (out_valid_a && out_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got inst_out=%h expected no output", inst_a);
        end else begin
          e   = q.pop_front();
          e32 = model(e.i, e.s, 32);
          e64 = model(e.i, e.s, 64);
          chk("sb_imm32", 64'(imm_a), e32);
          chk("sb_imm64", imm_b, e64);
          chk("sb_inst32", 64'(inst_a), 64'(e.i));
          chk("sb_inst64", 64'(inst_b), 64'(e.i));
          chk("sb_err", 64'(err_a), 64'(e.s == 3'd7));
          chk("sb_valid64", 64'(out_valid_b), 64'd1);
          outs++;
        end
      end
      hold    = out_valid_a && !out_ready;
      h_imm_a = imm_a;
      h_imm_b = imm_b;
      h_inst  = inst_a;
      if (in_valid && in_ready_a) q.push_back('{i: inst, s: imm_sel});
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int n, outs0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    inst = 32'h0; imm_sel = 3'd0;
    #2;
    chk("rst_out_valid", 64'(out_valid_a), 64'd0);
    chk("rst_in_ready", 64'(in_ready_a), 64'd1);
    chk("rst_imm64", imm_b, 64'd0);
    chk("rst_inst", 64'(inst_a), 64'd0);
    chk("rst_err", 64'(err_b), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    sweep(32'hFFF00093, 3'd0, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    sweep(32'h12345037, 3'd4, 32'h12345000, 64'h0000000012345000, 1'b0);
    sweep(32'h8000006F, 3'd3, 32'hFFF00000, 64'hFFFFFFFFFFF00000, 1'b0);
    sweep(32'h800002B7, 3'd4, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0);
    sweep(32'h03F01013, 3'd6, 32'h0000001F, 64'h000000000000003F, 1'b0);
    sweep(32'h000F8073, 3'd5, 32'h0000001F, 64'h000000000000001F, 1'b0);
    sweep(32'hFE000FA3, 3'd1, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    sweep(32'h80000063, 3'd2, 32'hFFFFF000, 64'hFFFFFFFFFFFFF000, 1'b0);
    sweep(32'h12345678, 3'd7, 32'h00000000, 64'h0000000000000000, 1'b1);
    sweep(32'h00000000, 3'd1, 32'h00000000, 64'h0000000000000000, 1'b0);
    tick();

    // Backpressure: two entries fill the buffer, the third waits at the input.
    outs0 = outs;
    out_ready = 1'b0;
    in_valid = 1'b1; inst = 32'hAAA00013; imm_sel = 3'd0;
    tick();
    chk("bp_ready_after1", 64'(in_ready_a), 64'd1);
    inst = 32'hBBB01023; imm_sel = 3'd1;
    tick();
    chk("bp_ready_after2", 64'(in_ready_a), 64'd0);
    inst = 32'hCCC0006F; imm_sel = 3'd3;
    tick();
    chk("bp_head_inst", 64'(inst_a), 64'h00000000AAA00013);
    chk("bp_still_full", 64'(in_ready_b), 64'd0);
    tick();
    out_ready = 1'b1;
    n = 0;
    do begin
      acc = in_ready_a;
      tick();
      n++;
    end while (!acc && n < 20);
    chk("bp_third_accepted", 64'(acc), 64'd1);
    in_valid = 1'b0;
    repeat (3) tick();
    chk("bp_out_count", 64'(outs - outs0), 64'd3);
    chk("bp_queue_empty", 64'(q.size()), 64'd0);

    // Flush while full with a concurrent input.
    out_ready = 1'b0;
    send(32'h11100013, 3'd0);
    send(32'h22200013, 3'd0);
    in_valid = 1'b1; inst = 32'h33300013; imm_sel = 3'd0; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", 64'(out_valid_a), 64'd0);
    chk("flush_in_ready", 64'(in_ready_a), 64'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("flush_no_emerge", 64'(out_valid_b), 64'd0);
    end

    // Asynchronous reset while full.
    out_ready = 1'b0;
    send(32'hFFF00093, 3'd0);
    send(32'h800002B7, 3'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid_a), 64'd0);
    chk("arst_imm32", 64'(imm_a), 64'd0);
    chk("arst_imm64", imm_b, 64'd0);
    chk("arst_in_ready", 64'(in_ready_b), 64'd1);
    tick();
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    send(32'h00500093, 3'd0);
    chk("arst_first_valid", 64'(out_valid_a), 64'd1);
    chk("arst_first_imm", 64'(imm_a), 64'd5);
    tick();

    // Randomized traffic with occasional flushes.
    for (int k = 0; k < 600; k++) begin
      in_valid  = ($urandom_range(3) != 0);
      inst      = $urandom;
      imm_sel   = 3'($urandom_range(7));
      out_ready = ($urandom_range(2) != 0);
      flush     = ($urandom_range(39) == 0);
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    chk("final_queue_empty", 64'(q.size()), 64'd0);
    chk("final_out_valid", 64'(out_valid_a), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
- Registered, handshaked immediate-generation stage; successor to the combinational immediate generator.
- Decodes I/S/B/J plus U, CSR-zimm and shift-amount formats, sign/zero-extending to a parametrised REG_WIDTH (32 or 64).
- Sits between fetch/decode and register-read. Valid/ready in both directions, a 2-entry skid buffer, and a flush.

Parameters:
- INST_WIDTH, 32, instruction width (fixed 32; other values unsupported).
- IMM_SEL_WIDTH, 3, immediate-select width.
- REG_WIDTH, 32, output immediate width; legal values are 32 or 64.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous; discards all buffered entries.
- in_valid  input  1  upstream entry valid.
- in_ready  output  1  stage can accept an entry.
- inst  input  INST_WIDTH  instruction word.
- imm_sel  input  IMM_SEL_WIDTH  format select.
- out_valid  output  1  output entry valid.
- out_ready  input  1  downstream accepts.
- imm_out  output  REG_WIDTH  generated immediate.
- inst_out  output  INST_WIDTH  instruction accompanying imm_out.
- sel_err  output  1  imm_sel was the reserved code (qualified by out_valid).

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: out_valid=0, in_ready=1, imm_out=0, inst_out=0, sel_err=0; both buffer entries invalid.
- Encodings, with S = sign replicated to REG_WIDTH. All immediates are computed from the input inst at capture.
  - 0 I: S(inst[31:20]).
  - 1 S: S({inst[31:25], inst[11:7]}).
  - 2 B: S({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - 3 J: S({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - 4 U: S({inst[31:12], 12'b0}); sign-extends to bit 63 when REG_WIDTH=64.
  - 5 Z: zero-extend inst[19:15].
  - 6 SH: zero-extend inst[25:20]. When REG_WIDTH=32, inst[25] is masked to 0.
  - 7 reserved: imm_out=0, sel_err=1.
- Handshakes: an input transfer occurs when in_valid && in_ready; an output transfer when out_valid && out_ready.
- Latency: 1 cycle. An entry accepted in cycle N appears with out_valid=1 in cycle N+1 if the main register is free or draining.
- Buffer: a main output register plus one skid register. in_ready is a registered signal equal to !skid_valid; no combinational path from out_ready to in_ready.
- State (main_v, skid_v):
  - EMPTY (0,0): accept loads main. → HALF.
  - HALF (1,0):
    - accept and drain: main reloads, stay HALF.
    - accept without drain: load skid → FULL.
    - drain without accept: → EMPTY.
  - FULL (1,1): in_ready=0. On drain, skid moves to main → HALF.
- Ordering: strictly FIFO; skid contents never bypass main.
- Stability: while out_valid=1 and out_ready=0, imm_out, inst_out and sel_err hold stable.
- flush: next state EMPTY, in_ready=1, out_valid=0.
  - Any input presented in the flush cycle is dropped.
  - flush has priority over a simultaneous accept or drain.
- Reset mid-operation: all entries lost immediately; outputs take reset values asynchronously.
- X-safety: imm_sel and inst are ignored while in_valid=0; the registers do not update.

Test Plan:
- Format sweep, out_ready=1. inst=0xFFF00093 with sel 0 → 0xFFFFFFFF. sel 4 with inst=0x12345037 → 0x12345000. sel 3 with inst=0x8000006F → 0xFFF00000. Each has out_valid exactly 1 cycle after accept.
- REG_WIDTH=64. U with inst=0x800002B7 → 0xFFFFFFFF80000000. SH with inst=0x03F01013 (shamt=63) → 0x3F. Z with rs1 field=31 → 0x1F.
- Backpressure. 3 back-to-back inputs with out_ready=0 → in_ready drops after the 2nd accept. Third held at input. Release out_ready → outputs appear in order 1, 2, 3 with no loss or duplication.
- Reserved sel=7 → imm_out=0, sel_err=1. Next entry with sel=1 has sel_err=0.
- flush while FULL with in_valid=1 → next cycle out_valid=0, in_ready=1. No flushed or concurrently presented entry ever emerges.
- rst_n asserted low mid-stream while FULL → outputs zero without a clock edge. After release, the first accept emerges 1 cycle later.
